// File: rtl/uart_json_pkg.sv
// Shared types and constants for the JSON-over-UART drive-state receiver.
// Holds RX/parser state enums, the "state": key literal, whitespace and range limits.
// UART_JSON_RX_PARITY_EN adds the RX_PARITY state to the receiver enum.
package uart_json_pkg;

`ifdef UART_JSON_RX_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;
`endif

    typedef enum logic [2:0] {
        PS_WAIT_OPEN, PS_MATCH_KEY, PS_DIGIT1, PS_DIGIT2, PS_CLOSE
    } parse_state_t;

    // Key literal "state": ; element 0 is the first byte on the wire.
    localparam int KEY_LEN = 8;
    localparam logic [KEY_LEN-1:0][7:0] KEY_BYTES =
        {8'h3A, 8'h22, 8'h65, 8'h74, 8'h61, 8'h74, 8'h73, 8'h22};

    localparam logic [7:0] WS_SPACE    = 8'h20;
    localparam logic [7:0] WS_CR       = 8'h0D;
    localparam logic [7:0] WS_LF       = 8'h0A;
    localparam logic [7:0] BRACE_OPEN  = 8'h7B;
    localparam logic [7:0] BRACE_CLOSE = 8'h7D;

    localparam logic [4:0] MAX_STATE = 5'd15;

    function automatic logic is_ws(input logic [7:0] b);
        return (b == WS_SPACE) || (b == WS_CR) || (b == WS_LF);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/uart_json_rx_byte.sv
// 8N1 (optionally 8E1) UART byte receiver with 2-flop input synchronizer; parity via UART_JSON_RX_PARITY_EN.
// byte_valid registered one cycle after the mid-stop-bit sample (~2 + CPB/2 + 9*CPB cycles from start edge).
// No backpressure: byte_valid is a one-cycle strobe the consumer must take; frame_err is a one-cycle strobe.
module uart_rx_byte
    import uart_json_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             stop_ok;
`ifdef UART_JSON_RX_PARITY_EN
    logic             par_ok_q, par_ok_d;
    assign stop_ok = sync_q && par_ok_q;
`else
    assign stop_ok = sync_q;
`endif

    // Next-state logic: synchronizer shift, bit-timing counter and RX FSM.
    always_comb begin
        meta_d       = uart_rx;
        sync_d       = meta_q;
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_JSON_RX_PARITY_EN
        par_ok_d     = par_ok_q;
`endif
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!sync_q) state_d = RX_START;
            end
            RX_START: begin
                // Mid-start-bit resample rejects short glitches silently.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
`ifdef UART_JSON_RX_PARITY_EN
                    if (bit_q == 3'd7) state_d = RX_PARITY;
`else
                    if (bit_q == 3'd7) state_d = RX_STOP;
`endif
                end
            end
`ifdef UART_JSON_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d    = '0;
                    par_ok_d = ~(^shift_q ^ sync_q);
                    state_d  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (stop_ok) begin
                        byte_valid_d = 1'b1;
                        state_d      = RX_IDLE;
                    end else begin
                        frame_err_d  = 1'b1;
                        state_d      = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                // A low stop bit may be a break; wait for idle before rearming.
                cnt_d = '0;
                if (sync_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver registers; synchronizer flops reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q       <= 1'b1;
            sync_q       <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_JSON_RX_PARITY_EN
            par_ok_q     <= 1'b0;
`endif
        end else begin
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_JSON_RX_PARITY_EN
            par_ok_q     <= par_ok_d;
`endif
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_json_rx.sv
// Top: UART receiver plus strict parser for {"state":N} frames driving a 4-bit drive state.
// state_valid/parse_err registered one cycle after the decisive byte; frame_err passes from the receiver.
// No backpressure: all outputs are one-cycle strobes; build option UART_JSON_RX_PARITY_EN enables even parity.
module uart_json_rx
    import uart_json_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [3:0] state_out,
    output logic       state_valid,
    output logic       frame_err,
    output logic       parse_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    logic [7:0] rx_byte;
    logic       byte_valid;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    parse_state_t ps_q, ps_d;
    logic [2:0]   idx_q, idx_d;
    logic [4:0]   acc_q, acc_d;
    logic [3:0]   state_out_q, state_out_d;
    logic         state_valid_q, state_valid_d;
    logic         parse_err_q, parse_err_d;
    logic [6:0]   acc_mult;

    // Parser next state: whitespace skip, '{' resync, key match, 1-2 digits, close brace.
    always_comb begin
        ps_d          = ps_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        state_out_d   = state_out_q;
        state_valid_d = 1'b0;
        parse_err_d   = 1'b0;
        // Second digit: acc is at most 9 here, so 7 bits hold the product exactly.
        acc_mult      = 7'(acc_q) * 7'd10 + {3'b000, rx_byte[3:0]};
        if (byte_valid && !is_ws(rx_byte)) begin
            if (rx_byte == BRACE_OPEN) begin
                ps_d  = PS_MATCH_KEY;
                idx_d = '0;
                acc_d = '0;
            end else begin
                case (ps_q)
                    PS_WAIT_OPEN: ps_d = PS_WAIT_OPEN;
                    PS_MATCH_KEY: begin
                        if (rx_byte == KEY_BYTES[idx_q]) begin
                            if (idx_q == 3'(KEY_LEN - 1)) ps_d = PS_DIGIT1;
                            else                         idx_d = idx_q + 1'b1;
                        end else begin
                            parse_err_d = 1'b1;
                            ps_d        = PS_WAIT_OPEN;
                        end
                    end
                    PS_DIGIT1: begin
                        if (is_digit(rx_byte)) begin
                            acc_d = {1'b0, rx_byte[3:0]};
                            ps_d  = PS_DIGIT2;
                        end else begin
                            parse_err_d = 1'b1;
                            ps_d        = PS_WAIT_OPEN;
                        end
                    end
                    PS_DIGIT2, PS_CLOSE: begin
                        if (ps_q == PS_DIGIT2 && is_digit(rx_byte)) begin
                            // Saturate so out-of-range values cannot wrap back into 0..15.
                            acc_d = (acc_mult > 7'd31) ? 5'd31 : acc_mult[4:0];
                            ps_d  = PS_CLOSE;
                        end else if (rx_byte == BRACE_CLOSE) begin
                            ps_d = PS_WAIT_OPEN;
                            if (acc_q <= MAX_STATE) begin
                                state_out_d   = acc_q[3:0];
                                state_valid_d = 1'b1;
                            end else begin
                                parse_err_d   = 1'b1;
                            end
                        end else begin
                            parse_err_d = 1'b1;
                            ps_d        = PS_WAIT_OPEN;
                        end
                    end
                    default: ps_d = PS_WAIT_OPEN;
                endcase
            end
        end
    end

    // Parser and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q          <= PS_WAIT_OPEN;
            idx_q         <= '0;
            acc_q         <= '0;
            state_out_q   <= '0;
            state_valid_q <= 1'b0;
            parse_err_q   <= 1'b0;
        end else begin
            ps_q          <= ps_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            state_out_q   <= state_out_d;
            state_valid_q <= state_valid_d;
            parse_err_q   <= parse_err_d;
        end
    end

    assign state_out   = state_out_q;
    assign state_valid = state_valid_q;
    assign parse_err   = parse_err_q;

endmodule

// File: tb/tb_uart_json_rx.sv
// Directed bench for uart_json_rx at 115200 baud with a 16x clock (CLKS_PER_BIT = 16).
// Strobe latency is measured from the start-bit edge of the closing brace.
// UART_JSON_RX_PARITY_EN adds the parity bit to every byte and a bad-parity scenario.
module tb_uart_json_rx;

    localparam int CPB = 16;
`ifdef UART_JSON_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    localparam int LAT_MIN = 2 + CPB / 2 + NBITS * CPB - 1;
    localparam int LAT_MAX = LAT_MIN + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [3:0] state_out;
    logic       state_valid;
    logic       frame_err;
    logic       parse_err;

    int n_cmp = 0;
    int n_err = 0;
    int sv_cnt = 0, fe_cnt = 0, pe_cnt = 0, multi_cnt = 0, wide_cnt = 0;
    logic prev_sv = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0;

    uart_json_rx #(
        .CLK_FREQ (1_843_200),
        .BAUD     (115_200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .state_out   (state_out),
        .state_valid (state_valid),
        .frame_err   (frame_err),
        .parse_err   (parse_err)
    );

    always #10 clk = ~clk;

    // Strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (state_valid) sv_cnt++;
        if (frame_err)   fe_cnt++;
        if (parse_err)   pe_cnt++;
        if (int'(state_valid) + int'(frame_err) + int'(parse_err) > 1) multi_cnt++;
        if ((state_valid && prev_sv) || (frame_err && prev_fe) || (parse_err && prev_pe)) wide_cnt++;
        prev_sv = state_valid;
        prev_fe = frame_err;
        prev_pe = parse_err;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_JSON_RX_PARITY_EN
        uart_rx = ^b;
        repeat (CPB) @(negedge clk);
`endif
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic idle(input int bits);
        uart_rx = 1'b1;
        repeat (bits * CPB) @(negedge clk);
    endtask

    task automatic check_deltas(input string name, input int sv0, input int fe0, input int pe0,
                                input int esv, input int efe, input int epe, input logic [3:0] est);
        n_cmp++;
        if ((sv_cnt - sv0) !== esv) begin
            n_err++;
            $display("FAIL %s state_valid count: got %0d want %0d", name, sv_cnt - sv0, esv);
        end
        n_cmp++;
        if ((fe_cnt - fe0) !== efe) begin
            n_err++;
            $display("FAIL %s frame_err count: got %0d want %0d", name, fe_cnt - fe0, efe);
        end
        n_cmp++;
        if ((pe_cnt - pe0) !== epe) begin
            n_err++;
            $display("FAIL %s parse_err count: got %0d want %0d", name, pe_cnt - pe0, epe);
        end
        n_cmp++;
        if (state_out !== est) begin
            n_err++;
            $display("FAIL %s state_out: got %0d want %0d", name, state_out, est);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({state_out, state_valid, frame_err, parse_err} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_hold outputs: got %b want 0000000", {state_out, state_valid, frame_err, parse_err});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({state_out, state_valid, frame_err, parse_err} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_release outputs: got %b want 0000000", {state_out, state_valid, frame_err, parse_err});
        end
    endtask

    task automatic test_single_frame;
        int sv0 = sv_cnt, fe0 = fe_cnt, pe0 = pe_cnt;
        int lat = -1;
        send_str("{\"state\":7");
        fork
            send_byte(8'h7D, 1'b1);
            begin
                for (int c = 1; c <= 400; c++) begin
                    @(negedge clk);
                    if (state_valid && lat < 0) lat = c;
                end
            end
        join
        idle(2);
        check_deltas("single_7", sv0, fe0, pe0, 1, 0, 0, 4'd7);
        n_cmp++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            n_err++;
            $display("FAIL latency: got %0d cycles want %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
    endtask

    task automatic test_whitespace;
        int sv0 = sv_cnt, fe0 = fe_cnt, pe0 = pe_cnt;
        send_str("{ \"state\" : 12 }\r\n");
        idle(2);
        check_deltas("ws_12", sv0, fe0, pe0, 1, 0, 0, 4'd12);
        send_str("{\"state\":3}");
        idle(2);
        check_deltas("ws_then_3", sv0, fe0, pe0, 2, 0, 0, 4'd3);
    endtask

    task automatic test_parse_err;
        int sv0 = sv_cnt, fe0 = fe_cnt, pe0 = pe_cnt;
        send_str("{\"state\":42}");
        idle(2);
        check_deltas("range_42", sv0, fe0, pe0, 0, 0, 1, 4'd3);
        sv0 = sv_cnt; pe0 = pe_cnt;
        send_str("{\"stat{\"state\":5}");
        idle(2);
        check_deltas("restart_5", sv0, fe0, pe0, 1, 0, 0, 4'd5);
        sv0 = sv_cnt; pe0 = pe_cnt;
        send_str("{\"state\":}{\"state\":123}{\"stxte\":1}");
        idle(2);
        check_deltas("grammar", sv0, fe0, pe0, 0, 0, 3, 4'd5);
    endtask

    task automatic test_frame_err;
        int sv0 = sv_cnt, fe0 = fe_cnt, pe0 = pe_cnt;
        send_byte(8'h41, 1'b0);
        idle(2);
        check_deltas("bad_stop", sv0, fe0, pe0, 0, 1, 0, 4'd5);
        send_str("{\"state\":1}");
        idle(2);
        check_deltas("after_bad_stop", sv0, fe0, pe0, 1, 1, 0, 4'd1);
        sv0 = sv_cnt; fe0 = fe_cnt;
        send_str("{\"sta");
        send_byte(8'h41, 1'b0);
        idle(1);
        send_str("te\":6}");
        idle(2);
        check_deltas("fe_keeps_parser", sv0, fe0, pe0, 1, 1, 0, 4'd6);
    endtask

    task automatic test_glitch;
        int sv0 = sv_cnt, fe0 = fe_cnt, pe0 = pe_cnt;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(4);
        check_deltas("glitch", sv0, fe0, pe0, 0, 0, 0, 4'd6);
    endtask

    task automatic test_back_to_back;
        int sv0 = sv_cnt, fe0 = fe_cnt, pe0 = pe_cnt;
        send_str("{\"state\":3}{\"state\":3}");
        idle(2);
        check_deltas("b2b_repeat", sv0, fe0, pe0, 2, 0, 0, 4'd3);
    endtask

    task automatic test_reset_mid_frame;
        int sv0, fe0, pe0;
        send_str("{\"sta");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        sv0 = sv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        n_cmp++;
        if (state_out !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid state_out: got %0d want 0", state_out);
        end
        send_str("ate\":2}");
        idle(2);
        check_deltas("reset_mid_drop", sv0, fe0, pe0, 0, 0, 0, 4'd0);
    endtask

`ifdef UART_JSON_RX_PARITY_EN
    task automatic test_parity;
        int sv0 = sv_cnt, fe0 = fe_cnt, pe0 = pe_cnt;
        logic [7:0] b = 8'h7B;
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = ~(^b);
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
        idle(2);
        check_deltas("bad_parity", sv0, fe0, pe0, 0, 1, 0, 4'd0);
        send_str("{\"state\":9}");
        idle(2);
        check_deltas("after_parity", sv0, fe0, pe0, 1, 1, 0, 4'd9);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset;
        test_single_frame;
        test_whitespace;
        test_parse_err;
        test_frame_err;
        test_glitch;
        test_back_to_back;
        test_reset_mid_frame;
`ifdef UART_JSON_RX_PARITY_EN
        test_parity;
`endif
        n_cmp++;
        if (multi_cnt !== 0) begin
            n_err++;
            $display("FAIL strobe_overlap: got %0d cycles want 0", multi_cnt);
        end
        n_cmp++;
        if (wide_cnt !== 0) begin
            n_err++;
            $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", wide_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
